// File: rtl/uart_rx_parity.sv
// rtl/uart_rx_parity.sv - UART receiver (8 data bits, optional parity, 1 stop) with byte FIFO
// Errors travel with each byte through the FIFO; overflow drops only the newest byte.
module uart_rx_parity #(
  parameter int DIVISOR_WIDTH = 16,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx,
  input  logic [DIVISOR_WIDTH-1:0] divisor,
  input  logic                     parity_en,
  input  logic                     parity_odd,
  output logic                     data_valid,
  input  logic                     data_ready,
  output logic [7:0]               data_payload,
  output logic                     data_parity_error,
  output logic                     data_framing_error,
  output logic                     overflow,
  output logic                     busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_PARITY    = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_HIGH = 3'd5;

  localparam logic [DIVISOR_WIDTH-1:0] CNT_ONE = 1;
  localparam logic [PTR_W:0]           PTR_ONE = 1;

  logic                     rx_meta_q, rx_meta_d;
  logic                     rx_sync_q, rx_sync_d;
  logic [2:0]               state_q, state_d;
  logic [DIVISOR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIVISOR_WIDTH-1:0] div_q, div_d;
  logic                     par_en_q, par_en_d;
  logic                     par_odd_q, par_odd_d;
  logic [7:0]               shreg_q, shreg_d;
  logic [2:0]               bit_idx_q, bit_idx_d;
  logic                     perr_q, perr_d;
  logic [9:0]               mem_q [FIFO_DEPTH];
  logic [9:0]               mem_d [FIFO_DEPTH];
  logic [PTR_W:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]           rd_ptr_q, rd_ptr_d;

  logic       sample;
  logic       push;
  logic       push_ferr;
  logic       fifo_empty;
  logic       fifo_full;
  logic       pop;
  logic       push_ok;
  logic [9:0] head;

  assign sample = (cnt_q == '0);

  always_comb begin
    rx_meta_d = rx;
    rx_sync_d = rx_meta_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    perr_d    = perr_q;
    push      = 1'b0;
    push_ferr = 1'b0;

    if (state_q != S_IDLE) begin
      cnt_d = sample ? div_q : (cnt_q - CNT_ONE);
    end

    case (state_q)
      S_IDLE: begin
        if (!rx_sync_q) begin
          // First sample lands (D>>1) cycles after t0, i.e. mid start bit.
          state_d   = S_START;
          div_d     = divisor;
          par_en_d  = parity_en;
          par_odd_d = parity_odd;
          cnt_d     = (divisor >> 1) - CNT_ONE;
        end
      end
      S_START: begin
        if (sample) begin
          if (rx_sync_q) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bit_idx_d = 3'd0;
            perr_d    = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (sample) begin
          shreg_d   = {rx_sync_q, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = par_en_q ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (sample) begin
          perr_d  = rx_sync_q ^ (^shreg_q) ^ par_odd_q;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (sample) begin
          push      = 1'b1;
          push_ferr = ~rx_sync_q;
          state_d   = rx_sync_q ? S_IDLE : S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: begin
        if (rx_sync_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Extra pointer bit distinguishes full from empty.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign pop        = ~fifo_empty & data_ready;
  assign push_ok    = push & (~fifo_full | pop);
  assign overflow   = push & fifo_full & ~pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = {push_ferr, perr_q, shreg_q};
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      perr_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_sync_q <= rx_sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      perr_q    <= perr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      mem_q     <= mem_d;
    end
  end

  assign head               = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign data_valid         = ~fifo_empty;
  assign data_payload       = data_valid ? head[7:0] : 8'h00;
  assign data_parity_error  = data_valid & head[8];
  assign data_framing_error = data_valid & head[9];
  assign busy               = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_parity.sv
// tb/tb_uart_rx_parity.sv - directed bench for uart_rx_parity
// Frames are driven 1 ns after the rising edge; outputs are observed on the falling edge.
module tb_uart_rx_parity;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic [15:0] divisor;
  logic        parity_en;
  logic        parity_odd;
  logic        data_valid;
  logic        data_ready;
  logic [7:0]  data_payload;
  logic        data_parity_error;
  logic        data_framing_error;
  logic        overflow;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int ovf_cnt  = 0;
  int busy_cnt = 0;

  uart_rx_parity #(.DIVISOR_WIDTH(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .rx(rx), .divisor(divisor),
    .parity_en(parity_en), .parity_odd(parity_odd),
    .data_valid(data_valid), .data_ready(data_ready), .data_payload(data_payload),
    .data_parity_error(data_parity_error), .data_framing_error(data_framing_error),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (overflow) ovf_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic with_par, input logic par_bit,
                            input logic stop_bit, input int extra_low);
    int bt;
    bt = int'(divisor) + 1;
    rx = 1'b0;
    tick(bt);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(bt);
    end
    if (with_par) begin
      rx = par_bit;
      tick(bt);
    end
    rx = stop_bit;
    tick(bt + extra_low);
    rx = 1'b1;
    tick(2 * bt);
  endtask

  task automatic read_entry(output logic [7:0] p, output logic pe, output logic fe, output logic ok);
    ok = 1'b0;
    p  = 8'h00;
    pe = 1'b0;
    fe = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (data_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      p  = data_payload;
      pe = data_parity_error;
      fe = data_framing_error;
      data_ready = 1'b1;
      @(posedge clk);
      #1;
      data_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; rx = 1'b1; divisor = 16'd2; parity_en = 1'b1; parity_odd = 1'b0; data_ready = 1'b0;
    tick(3);
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", data_valid); end
    n_checks++; if (data_payload !== 8'h00) begin n_fail++; $display("FAIL reset_payload got %h exp 00", data_payload); end
    n_checks++; if ({data_parity_error, data_framing_error, overflow, busy} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags got %b exp 0000", {data_parity_error, data_framing_error, overflow, busy}); end
    reset = 1'b0;
    tick(3);
  endtask

  task automatic test_even_parity();
    logic [7:0] p; logic pe, fe, ok;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 0);
    read_entry(p, pe, fe, ok);
    n_checks++; if (!ok || p !== 8'hA5 || pe !== 1'b0 || fe !== 1'b0) begin
      n_fail++; $display("FAIL a5_even got ok=%b %h pe=%b fe=%b exp 1 a5 0 0", ok, p, pe, fe); end
    @(negedge clk);
    n_checks++; if (data_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL a5_after got valid=%b busy=%b exp 0 0", data_valid, busy); end
    tick(1);
  endtask

  task automatic test_parity_error();
    logic [7:0] p; logic pe, fe, ok;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 0);
    read_entry(p, pe, fe, ok);
    n_checks++; if (!ok || p !== 8'h3C || pe !== 1'b1 || fe !== 1'b0) begin
      n_fail++; $display("FAIL 3c_perr got ok=%b %h pe=%b fe=%b exp 1 3c 1 0", ok, p, pe, fe); end
    parity_odd = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 0);
    read_entry(p, pe, fe, ok);
    n_checks++; if (!ok || p !== 8'hA5 || pe !== 1'b0 || fe !== 1'b0) begin
      n_fail++; $display("FAIL a5_odd got ok=%b %h pe=%b fe=%b exp 1 a5 0 0", ok, p, pe, fe); end
    parity_odd = 1'b0;
    parity_en  = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 0);
    read_entry(p, pe, fe, ok);
    n_checks++; if (!ok || p !== 8'h3C || pe !== 1'b0 || fe !== 1'b0) begin
      n_fail++; $display("FAIL 3c_nopar got ok=%b %h pe=%b fe=%b exp 1 3c 0 0", ok, p, pe, fe); end
  endtask

  task automatic test_framing();
    logic [7:0] p; logic pe, fe, ok;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 2);
    send_frame(8'h01, 1'b0, 1'b0, 1'b1, 0);
    read_entry(p, pe, fe, ok);
    n_checks++; if (!ok || p !== 8'h55 || pe !== 1'b0 || fe !== 1'b1) begin
      n_fail++; $display("FAIL 55_ferr got ok=%b %h pe=%b fe=%b exp 1 55 0 1", ok, p, pe, fe); end
    read_entry(p, pe, fe, ok);
    n_checks++; if (!ok || p !== 8'h01 || pe !== 1'b0 || fe !== 1'b0) begin
      n_fail++; $display("FAIL 01_clean got ok=%b %h pe=%b fe=%b exp 1 01 0 0", ok, p, pe, fe); end
    tick(10);
    @(negedge clk);
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL no_third got valid=%b exp 0", data_valid); end
    tick(1);
  endtask

  task automatic test_overflow();
    logic [7:0] p; logic pe, fe, ok;
    int ovf0;
    ovf0 = ovf_cnt;
    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b0, 1'b1, 0);
    @(negedge clk);
    n_checks++; if (ovf_cnt - ovf0 !== 0) begin n_fail++; $display("FAIL ovf_early got %0d exp 0", ovf_cnt - ovf0); end
    n_checks++; if (data_valid !== 1'b1 || data_payload !== 8'h10) begin
      n_fail++; $display("FAIL head_hold got valid=%b %h exp 1 10", data_valid, data_payload); end
    tick(1);
    send_frame(8'h14, 1'b0, 1'b0, 1'b1, 0);
    @(negedge clk);
    n_checks++; if (ovf_cnt - ovf0 !== 1) begin n_fail++; $display("FAIL ovf_count got %0d exp 1", ovf_cnt - ovf0); end
    tick(1);
    for (int i = 0; i < 4; i++) begin
      read_entry(p, pe, fe, ok);
      n_checks++; if (!ok || p !== 8'h10 + 8'(i) || pe !== 1'b0 || fe !== 1'b0) begin
        n_fail++; $display("FAIL ovf_pop%0d got ok=%b %h exp 1 %h", i, ok, p, 8'h10 + 8'(i)); end
    end
    tick(5);
    @(negedge clk);
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained got valid=%b exp 0", data_valid); end
    tick(1);
  endtask

  task automatic test_glitch();
    int b0, ovf0;
    divisor = 16'd15;
    b0 = busy_cnt;
    ovf0 = ovf_cnt;
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(40);
    @(negedge clk);
    n_checks++; if (busy_cnt - b0 <= 0) begin n_fail++; $display("FAIL glitch_busy got %0d busy cycles exp >0", busy_cnt - b0); end
    n_checks++; if (busy !== 1'b0 || data_valid !== 1'b0 || ovf_cnt !== ovf0) begin
      n_fail++; $display("FAIL glitch_idle got busy=%b valid=%b ovf=%0d exp 0 0 %0d", busy, data_valid, ovf_cnt, ovf0); end
    tick(1);
    divisor = 16'd2;
  endtask

  task automatic test_reset_midframe();
    logic [7:0] p; logic pe, fe, ok;
    logic [7:0] b;
    send_frame(8'h21, 1'b0, 1'b0, 1'b1, 0);
    send_frame(8'h42, 1'b0, 1'b0, 1'b1, 0);
    b = 8'h99;
    rx = 1'b0;
    tick(3);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      tick(3);
    end
    rx = b[4];
    tick(1);
    @(negedge clk);
    n_checks++; if (busy !== 1'b1 || data_valid !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset got busy=%b valid=%b exp 1 1", busy, data_valid); end
    reset = 1'b1;
    #1;
    n_checks++; if ({data_valid, data_payload, data_parity_error, data_framing_error, overflow, busy} !== 13'h0) begin
      n_fail++; $display("FAIL midreset_outs got %h exp 0", {data_valid, data_payload, data_parity_error, data_framing_error, overflow, busy}); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    rx = 1'b1;
    tick(6);
    send_frame(8'h7E, 1'b0, 1'b0, 1'b1, 0);
    read_entry(p, pe, fe, ok);
    n_checks++; if (!ok || p !== 8'h7E || pe !== 1'b0 || fe !== 1'b0) begin
      n_fail++; $display("FAIL 7e_after_reset got ok=%b %h pe=%b fe=%b exp 1 7e 0 0", ok, p, pe, fe); end
    @(negedge clk);
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL 7e_only got valid=%b exp 0", data_valid); end
    tick(1);
  endtask

  initial begin
    test_reset();
    test_even_parity();
    test_parity_error();
    test_framing();
    test_overflow();
    test_glitch();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_parity.md
Name: uart_rx_parity

Overview:
- Receive side of the SoC's UART link: 8 data bits, LSB first, optional even/odd parity, 1 stop bit.
- Recovers bytes from the asynchronous rx pin and flags parity and framing errors per byte.
- Buffers bytes in a small FIFO and presents them on a valid/ready stream to the CPU-side peripheral register logic.
- Runs in the CPU clock domain; baud rate is set at runtime through a divisor.

Parameters:
- DIVISOR_WIDTH, 16, width of the divisor input.
- FIFO_DEPTH, 4, received-byte FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  CPU clock
- reset  in  1  asynchronous, active-high reset
- rx  in  1  serial line; asynchronous; idle high
- divisor  in  DIVISOR_WIDTH  clocks per bit minus 1; legal values ≥2
- parity_en  in  1  1 = frame carries a parity bit
- parity_odd  in  1  0 = even parity, 1 = odd parity
- data_valid  out  1  FIFO head valid
- data_ready  in  1  consumer accepts the head entry
- data_payload  out  8  received byte
- data_parity_error  out  1  parity mismatch for the head byte; 0 when parity_en=0
- data_framing_error  out  1  stop bit sampled low for the head byte
- overflow  out  1  one-cycle pulse: a completed byte was dropped because the FIFO was full
- busy  out  1  receiver is not in IDLE

Behaviour:
- Reset values:
  - Two-flop rx synchronizer = 1.
  - State = IDLE; FIFO empty.
  - data_valid, data_payload, both error flags, overflow, busy = 0.
- Config latch: divisor, parity_en and parity_odd are captured when leaving IDLE. Changing them mid-frame has no effect until the next frame.
- Timing reference:
  - D = latched divisor; t0 = first cycle the synchronized rx is 0 in IDLE.
  - Sample k (k=0 start, 1..8 data, then parity, then stop) happens at t0 + (D>>1) + k·(D+1).
  - The bit counter loads D>>1 at t0, decrements every cycle, samples at 0, then reloads D.
- States:
  - IDLE: on rx_sync==0, go to START.
  - START: at sample, rx_sync==1 means a glitch: return to IDLE with no output. Otherwise go to DATA.
  - DATA: shift each sample into bit [i], LSB first. After bit 7, go to PARITY if parity_en, else STOP.
  - PARITY: perr = sample XOR (XOR of data bits) XOR parity_odd.
  - STOP: sample 1 → push {byte, perr, 0} and go to IDLE the next cycle. Sample 0 → push {byte, perr, 1} and go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_sync==1, then go to IDLE. A line held low never produces further bytes.
- Push is always performed, even with errors; errors travel with the byte. The push occurs in the stop-sample cycle; data_valid rises the following cycle if the FIFO was empty.
- FIFO:
  - Pop when data_valid && data_ready; the head advances the next cycle.
  - Push while full with no pop in the same cycle: byte dropped, overflow=1 for exactly that cycle, FIFO contents unchanged.
  - Push while full with a simultaneous pop: accepted, no overflow.
  - Push and pop when empty: the entry is stored; no bypass.
  - Output order is strictly FIFO; pointers wrap modulo FIFO_DEPTH.
- data_payload and the flags are stable while data_valid && !data_ready.
- busy = (state != IDLE).
- Reset mid-frame or mid-FIFO: everything returns to its reset values immediately; the partial byte and stored bytes are discarded.

Test Plan:
- divisor=2 (48 MHz clk, 16 Mbaud), parity_en=1, parity_odd=0; send 0xA5 with parity 0, stop 1 → one data_valid, payload 0xA5, perr=0, ferr=0; busy=0 afterwards.
- Same config; send 0x3C with parity bit 1 → payload 0x3C, data_parity_error=1, ferr=0. Then parity_en=0, send 0x3C with no parity bit → perr=0.
- Send 0x55, hold rx low through the stop bit plus 2/3 bit time, then release high; send 0x01 → first entry 0x55 with ferr=1, second entry 0x01 clean, no spurious third byte.
- FIFO_DEPTH=4, data_ready=0, send 0x10..0x14 → exactly one overflow pulse, at the 5th stop sample. Raise data_ready → 0x10, 0x11, 0x12, 0x13 popped in order, then data_valid=0.
- divisor=15, rx low for 3 clocks then high → busy pulses; FIFO stays empty; no overflow.
- Assert reset for 1 cycle during data bit 4 with 2 bytes queued → all outputs return to reset values; a subsequent 0x7E frame is received correctly as the only entry.
